// File: rtl/serial_uart_pkg.sv
// Shared constants for the serial_uart transceiver.
//   - default baud divider and strobe stretch length
//   - RX / TX state encodings
//   - UART line idle level
package serial_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF  = 104;  // 12 MHz / 115200
    localparam int unsigned STROBE_CYCLES_DEF = 4;
    localparam int unsigned SYNC_STAGES_DEF   = 2;

    localparam logic UART_IDLE = 1'b1;

    localparam logic [2:0] RXS_IDLE   = 3'd0;
    localparam logic [2:0] RXS_START  = 3'd1;
    localparam logic [2:0] RXS_DATA   = 3'd2;
    localparam logic [2:0] RXS_STOP   = 3'd3;
    localparam logic [2:0] RXS_WAITHI = 3'd4;

    localparam logic [1:0] TXS_IDLE  = 2'd0;
    localparam logic [1:0] TXS_START = 2'd1;
    localparam logic [1:0] TXS_DATA  = 2'd2;
    localparam logic [1:0] TXS_STOP  = 2'd3;

    typedef enum logic [2:0] {
        RX_IDLE   = RXS_IDLE,
        RX_START  = RXS_START,
        RX_DATA   = RXS_DATA,
        RX_STOP   = RXS_STOP,
        RX_WAITHI = RXS_WAITHI
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = TXS_IDLE,
        TX_START = TXS_START,
        TX_DATA  = TXS_DATA,
        TX_STOP  = TXS_STOP
    } tx_state_e;

endpackage

// File: rtl/serial_uart_rx.sv
// UART 8N1 receiver: rx synchroniser, centre-sampling FSM, recv_strobe
// stretcher and framing error pulse.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   rx                asynchronous serial input (idle high)
//   receive_data      last byte received with a good stop bit
//   recv_strobe       high STROBE_CYCLES clocks after a good byte
//   framing_err       one-clock pulse when the stop bit samples 0
//
// state     | meaning
// RX_IDLE   | line idle, waiting for a falling edge
// RX_START  | half-bit wait, then confirm start bit is still low
// RX_DATA   | sampling 8 data bits at bit centres, LSB first
// RX_STOP   | sampling the stop bit at its centre
// RX_WAITHI | stop bit was low; wait for line to return high
module serial_uart_rx
    import serial_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] receive_data,
    output logic       recv_strobe,
    output logic       framing_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic [SW-1:0]          stb_cnt_q, stb_cnt_d;
    logic                   ferr_q, ferr_d;
    logic                   rxs;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ferr_d    = 1'b0;
        // Stretcher runs on its own so a new frame can start under the strobe.
        stb_cnt_d = (stb_cnt_q != '0) ? stb_cnt_q - SW'(1) : stb_cnt_q;

        unique case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    state_d = RX_START;
                    cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = CW'(CLKS_PER_BIT - 1);
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = CW'(CLKS_PER_BIT - 1);
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        data_d    = shift_q;
                        stb_cnt_d = SW'(STROBE_CYCLES);
                        state_d   = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_WAITHI: begin
                if (rxs) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q    <= {SYNC_STAGES{UART_IDLE}};
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            stb_cnt_q <= '0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            stb_cnt_q <= stb_cnt_d;
            ferr_q    <= ferr_d;
        end
    end

    assign receive_data = data_q;
    assign recv_strobe  = (stb_cnt_q != '0);
    assign framing_err  = ferr_q;

endmodule

// File: rtl/serial_uart.sv
// Byte-level UART transceiver between the rx/tx pins and the serial
// register command engine. RX lives in serial_uart_rx; TX is inline.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   rx / tx           serial pins, idle high
//   receive_data      last good received byte
//   recv_strobe       STROBE_CYCLES-long pulse per good received byte
//   send_data         byte to send, latched when a frame starts
//   data_avail        level: send_data holds a byte to send
//   send_strobe       STROBE_CYCLES-long pulse when send_data is latched
//   framing_err       one-clock pulse on a low stop bit
//   tx_busy           high from start bit through end of stop bit
//
// state    | meaning
// TX_IDLE  | tx high, waiting for data_avail
// TX_START | driving the start bit
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving the stop bit
module serial_uart
    import serial_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] receive_data,
    output logic       recv_strobe,
    input  logic [7:0] send_data,
    input  logic       data_avail,
    output logic       send_strobe,
    output logic       framing_err,
    output logic       tx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);

    serial_uart_rx #(
        .CLKS_PER_BIT  (CLKS_PER_BIT),
        .STROBE_CYCLES (STROBE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .receive_data (receive_data),
        .recv_strobe  (recv_strobe),
        .framing_err  (framing_err)
    );

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] sstb_cnt_q, sstb_cnt_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        sstb_cnt_d = (sstb_cnt_q != '0) ? sstb_cnt_q - SW'(1) : sstb_cnt_q;

        unique case (tx_state_q)
            TX_IDLE: begin
                if (data_avail) begin
                    tx_shift_d = send_data;
                    tx_d       = ~UART_IDLE;
                    busy_d     = 1'b1;
                    sstb_cnt_d = SW'(STROBE_CYCLES);
                    tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = 3'd0;
                    tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = CW'(CLKS_PER_BIT - 1);
                    if (tx_idx_q == 3'd7) begin
                        tx_d       = UART_IDLE;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_idx_d   = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    busy_d     = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= UART_IDLE;
            busy_q     <= 1'b0;
            sstb_cnt_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            sstb_cnt_q <= sstb_cnt_d;
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign send_strobe = (sstb_cnt_q != '0);

endmodule

// File: tb/tb_serial_uart.sv
module tb_serial_uart;

    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       tx;
    logic [7:0] receive_data;
    logic       recv_strobe;
    logic [7:0] send_data;
    logic       data_avail;
    logic       send_strobe;
    logic       framing_err;
    logic       tx_busy;

    int n_chk  = 0;
    int n_pass = 0;

    int cyc        = 0;
    int rs_cycles  = 0;
    int fe_cycles  = 0;
    int ss_cycles  = 0;
    int ss_rises   = 0;
    int ss_rise_at = 0;
    int ss_last    = 0;
    logic ss_prev  = 1'b0;

    int rs0, fe0, ss0;

    serial_uart #(
        .CLKS_PER_BIT  (8),
        .STROBE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .tx           (tx),
        .receive_data (receive_data),
        .recv_strobe  (recv_strobe),
        .send_data    (send_data),
        .data_avail   (data_avail),
        .send_strobe  (send_strobe),
        .framing_err  (framing_err),
        .tx_busy      (tx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (recv_strobe) rs_cycles++;
        if (framing_err) fe_cycles++;
        if (send_strobe) ss_cycles++;
        if (send_strobe && !ss_prev) begin
            ss_rises++;
            ss_last    = ss_rise_at;
            ss_rise_at = cyc;
        end
        ss_prev = send_strobe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives a full frame on rx; leaves rx at the stop-bit level.
    task automatic send_rx_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        // Reset with rx low and data_avail high
        reset      = 1'b0;
        rx         = 1'b0;
        data_avail = 1'b1;
        send_data  = 8'h3C;
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_sstb", send_strobe, 0);
        check("rst_rstb", recv_strobe, 0);
        check("rst_rdata", receive_data, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ss_rises", ss_rises, 0);

        // Release: first frame (0x3C) starts one clock later
        rx    = 1'b1;
        reset = 1'b1;
        tick(1);
        check("rel_tx_fall", tx, 0);
        check("rel_sstb", send_strobe, 1);
        check("rel_busy", tx_busy, 1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx3c_bit%0d", k), tx, frame_bit(8'h3C, k));
            if (k == 1) begin
                check("tx3c_sstb_low", send_strobe, 0);
                send_data = 8'hC3;
            end
            tick(CPB);
        end
        check("gap_tx_high", tx, 1);
        check("gap_busy_low", tx_busy, 0);
        tick(1);
        check("b2b_tx_fall", tx, 0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("txc3_bit%0d", k), tx, frame_bit(8'hC3, k));
            if (k == 1) data_avail = 1'b0;
            tick(CPB);
        end
        tick(3);
        check("b2b_idle_busy", tx_busy, 0);
        check("b2b_idle_tx", tx, 1);
        check("b2b_ss_rises", ss_rises, 2);
        check("b2b_ss_spacing", ss_rise_at - ss_last, 81);
        check("b2b_ss_cycles", ss_cycles, 8);

        // RX good frame
        rs0 = rs_cycles; fe0 = fe_cycles;
        send_rx_frame(8'hA5, 1'b1);
        tick(8);
        check("rx_a5_data", receive_data, 8'hA5);
        check("rx_a5_strobe_len", rs_cycles - rs0, 4);
        check("rx_a5_no_ferr", fe_cycles - fe0, 0);

        // Framing error then held-low break
        rs0 = rs_cycles; fe0 = fe_cycles;
        send_rx_frame(8'h00, 1'b0);
        tick(50);
        rx = 1'b1;
        tick(10);
        check("brk_one_ferr", fe_cycles - fe0, 1);
        check("brk_no_strobe", rs_cycles - rs0, 0);
        check("brk_data_kept", receive_data, 8'hA5);
        rs0 = rs_cycles;
        send_rx_frame(8'h01, 1'b1);
        tick(8);
        check("rx_01_data", receive_data, 8'h01);
        check("rx_01_strobe_len", rs_cycles - rs0, 4);

        // Glitch on rx
        rs0 = rs_cycles; fe0 = fe_cycles;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(20);
        check("glitch_no_strobe", rs_cycles - rs0, 0);
        check("glitch_no_ferr", fe_cycles - fe0, 0);
        check("glitch_data_kept", receive_data, 8'h01);

        // Full duplex: TX 0x55 while RX 0xFF
        rs0 = rs_cycles; fe0 = fe_cycles;
        send_data  = 8'h55;
        data_avail = 1'b1;
        fork
            begin
                tick(1);
                data_avail = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    check($sformatf("dup_tx_bit%0d", k), tx, frame_bit(8'h55, k));
                    tick(CPB);
                end
            end
            begin
                send_rx_frame(8'hFF, 1'b1);
            end
        join
        tick(8);
        check("dup_rx_data", receive_data, 8'hFF);
        check("dup_rx_strobe_len", rs_cycles - rs0, 4);
        check("dup_no_ferr", fe_cycles - fe0, 0);
        check("dup_ss_rises", ss_rises, 3);
        check("dup_busy_low", tx_busy, 0);

        // Reset in the middle of TX data bit 3
        send_data  = 8'h55;
        data_avail = 1'b1;
        tick(1);
        check("mid_tx_fall", tx, 0);
        data_avail = 1'b0;
        tick(35);
        check("mid_bit3_low", tx, 0);
        ss0   = ss_rises;
        reset = 1'b0;
        tick(1);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_sstb", send_strobe, 0);
        check("mid_rst_rdata", receive_data, 0);
        reset = 1'b1;
        tick(20);
        check("mid_after_tx", tx, 1);
        check("mid_no_more_sstb", ss_rises - ss0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
